// File: rtl/tns_chunk_sequencer_if.sv
// rtl/tns_chunk_sequencer_if.sv - word input, encoder and code output signals of the chunk sequencer
interface tns_chunk_sequencer_if #(
  parameter int CHUNK_W = 4,
  parameter int NCHUNK  = 4,
  parameter int CODE_W  = 6
);
  logic                        in_valid;
  logic                        in_ready;
  logic [CHUNK_W*NCHUNK-1:0]   in_data;
  logic [CHUNK_W-1:0]          enc_data;
  logic [CODE_W-1:0]           enc_code;
  logic                        out_valid;
  logic                        out_ready;
  logic [CODE_W-1:0]           out_code;
  logic                        out_last;
  logic                        busy;

  modport slave (
    input  in_valid, in_data, enc_code, out_ready,
    output in_ready, enc_data, out_valid, out_code, out_last, busy
  );

  modport master (
    output in_valid, in_data, enc_code, out_ready,
    input  in_ready, enc_data, out_valid, out_code, out_last, busy
  );
endinterface

// File: rtl/tns_chunk_sequencer.sv
// rtl/tns_chunk_sequencer.sv - slices input words into chunks for a free-running TNS encoder
module tns_chunk_sequencer #(
  parameter int CHUNK_W  = 4,
  parameter int NCHUNK   = 4,
  parameter int CODE_W   = 6,
  parameter int INIT_CYC = 2
) (
  input  logic                  clock,
  input  logic                  rst_n,
  tns_chunk_sequencer_if.slave  bus
);
  localparam int IDX_W = $clog2(NCHUNK);
  localparam int CNT_W = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(INIT_CYC - 1);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_RUN} state_e;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           init_cnt_q, init_cnt_d;
  logic [CHUNK_W-1:0]         held_q, held_d;
  logic [CHUNK_W*NCHUNK-1:0]  word_q, word_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       out_valid_q, out_valid_d;
  logic                       out_last_q, out_last_d;
  logic [CHUNK_W-1:0]         cur_chunk;
  logic [CHUNK_W-1:0]         enc_data_c;
  logic                       in_ready_c;
  logic                       issue;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      held_q      <= '0;
      word_q      <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      held_q      <= held_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  always_comb begin
    cur_chunk = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (idx_q == IDX_W'(k)) cur_chunk = word_q[k*CHUNK_W +: CHUNK_W];
    end
  end

  // Outside an issue cycle the encoder keeps seeing the last issued chunk, so its
  // registered code stays valid for as long as the consumer stalls.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    held_d      = held_q;
    word_d      = word_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    enc_data_c  = held_q;
    in_ready_c  = 1'b0;
    issue       = 1'b0;
    case (state_q)
      ST_INIT: begin
        enc_data_c = '0;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LAST_CNT) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        in_ready_c = 1'b1;
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
        if (bus.in_valid) begin
          word_d  = bus.in_data;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        issue = !out_valid_q || bus.out_ready;
        if (issue) begin
          enc_data_c  = cur_chunk;
          held_d      = cur_chunk;
          out_valid_d = 1'b1;
          out_last_d  = (idx_q == LAST_IDX);
          idx_d       = idx_q + 1'b1;
          // Accepting alongside the last chunk keeps words back-to-back.
          if (idx_q == LAST_IDX) begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
              word_d = bus.in_data;
              idx_d  = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.enc_data  = enc_data_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_code  = bus.enc_code;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state_q != ST_IDLE) || out_valid_q;
endmodule

// File: tb/tb_tns_chunk_sequencer.sv
// tb/tb_tns_chunk_sequencer.sv - self-checking bench for tns_chunk_sequencer
module tb_tns_chunk_sequencer;
  localparam int CW = 4;
  localparam int NC = 4;
  localparam int DW = CW * NC;
  localparam int CODEW = 6;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  tns_chunk_sequencer_if #(.CHUNK_W(CW), .NCHUNK(NC), .CODE_W(CODEW)) bus ();

  tns_chunk_sequencer #(.CHUNK_W(CW), .NCHUNK(NC), .CODE_W(CODEW), .INIT_CYC(2)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Encoder stand-in: registered code, no reset, r_bit forced clear by a zero input.
  logic             r_bit = 1'b1;
  logic [CODEW-1:0] enc_q = '0;
  always @(posedge clock) begin
    enc_q <= {(^bus.enc_data) ^ r_bit, bus.enc_data, r_bit};
    r_bit <= r_bit & (|bus.enc_data);
  end
  assign bus.enc_code = enc_q;

  int checks = 0;
  int errors = 0;

  function automatic logic [CODEW-1:0] code_of(input logic [CW-1:0] c);
    return {^c, c, 1'b0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [CODEW-1:0] code;
    logic             last;
  } beat_t;

  beat_t            exp_q[$];
  beat_t            b;
  logic             prev_stall = 1'b0;
  logic [CODEW-1:0] prev_code;
  logic             prev_last;
  logic [DW-1:0]    acc_word;

  always @(negedge clock) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_code", 32'(bus.out_code), 32'(prev_code));
        chk("stall_last", 32'(bus.out_last), 32'(prev_last));
      end
      if (bus.out_valid && !bus.out_ready)
        chk("stall_enc_idem", 32'(code_of(bus.enc_data)), 32'(bus.out_code));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_beat actual=%0h expected=none at %0t", bus.out_code, $time);
        end else begin
          b = exp_q.pop_front();
          chk("sb_code", 32'(bus.out_code), 32'(b.code));
          chk("sb_last", 32'(bus.out_last), 32'(b.last));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        acc_word = bus.in_data;
        for (int k = 0; k < NC; k++)
          exp_q.push_back('{code: code_of(acc_word[k*CW +: CW]), last: (k == NC - 1)});
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_code  = bus.out_code;
      prev_last  = bus.out_last;
    end
  end

  typedef struct {
    logic [DW-1:0] word;
    logic [CW-1:0] ch [NC];
  } vec_t;

  vec_t vecs [6];

  function automatic vec_t mk(input logic [DW-1:0] w, input logic [CW-1:0] c0,
                              input logic [CW-1:0] c1, input logic [CW-1:0] c2,
                              input logic [CW-1:0] c3);
    vec_t v;
    v.word = w;
    v.ch[0] = c0; v.ch[1] = c1; v.ch[2] = c2; v.ch[3] = c3;
    return v;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    while ((exp_q.size() != 0 || bus.busy) && n < 60) begin
      step();
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d pending expected=0", exp_q.size());
    end
  endtask

  // Single word from IDLE with out_ready held high; ends in the cycle after the last beat.
  task automatic run_vec(input vec_t v);
    bus.in_valid = 1'b1;
    bus.in_data  = v.word;
    @(negedge clock);
    chk("vec_accept_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    bus.in_data  = DW'($urandom);
    for (int k = 0; k <= NC; k++) begin
      @(negedge clock);
      if (k < NC) begin
        chk("vec_enc_data", 32'(bus.enc_data), 32'(v.ch[k]));
        chk("vec_in_ready", 32'(bus.in_ready), 32'(k == NC - 1));
      end
      if (k > 0) begin
        chk("vec_out_valid", 32'(bus.out_valid), 32'd1);
        chk("vec_out_code", 32'(bus.out_code), 32'(code_of(v.ch[k-1])));
        chk("vec_out_last", 32'(bus.out_last), 32'(k == NC));
      end
      step();
    end
    @(negedge clock);
    chk("vec_valid_clear", 32'(bus.out_valid), 32'd0);
    chk("vec_enc_hold", 32'(bus.enc_data), 32'(v.ch[NC-1]));
    step();
  endtask

  logic [CW-1:0] seq [8];

  initial begin
    vecs[0] = mk(16'hB3A1, 4'h1, 4'hA, 4'h3, 4'hB);
    vecs[1] = mk(16'h0FF0, 4'h0, 4'hF, 4'hF, 4'h0);
    vecs[2] = mk(16'h8000, 4'h0, 4'h0, 4'h0, 4'h8);
    vecs[3] = mk(16'h000F, 4'hF, 4'h0, 4'h0, 4'h0);
    vecs[4] = mk(16'h5A5A, 4'hA, 4'h5, 4'hA, 4'h5);
    vecs[5] = mk(16'h1111, 4'h1, 4'h1, 4'h1, 4'h1);
    seq = '{4'h1, 4'hA, 4'h3, 4'hB, 4'h0, 4'hF, 4'hF, 4'h0};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_enc_data", 32'(bus.enc_data), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd1);

    // Reset release with a word already waiting
    step();
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h4321;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      chk("t1_in_ready", 32'(bus.in_ready), 32'(c == 3));
      chk("t1_enc_zero", 32'(bus.enc_data), 32'd0);
      step();
    end
    bus.in_valid = 1'b0;
    drain();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);
    drain();

    // Two words back-to-back
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hB3A1;
    @(negedge clock);
    chk("t3_first_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_data = 16'h0FF0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clock);
      if (c <= 8) begin
        chk("t3_enc_data", 32'(bus.enc_data), 32'(seq[c-1]));
        chk("t3_in_ready", 32'(bus.in_ready), 32'(c == 4 || c == 8));
      end
      if (c >= 2) begin
        chk("t3_out_valid", 32'(bus.out_valid), 32'd1);
        chk("t3_out_code", 32'(bus.out_code), 32'(code_of(seq[c-2])));
        chk("t3_out_last", 32'(bus.out_last), 32'(c == 5 || c == 9));
      end
      step();
      if (c == 4) bus.in_valid = 1'b0;
    end
    drain();

    // Three-cycle stall after beat 2
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h5555;
    step();
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    bus.out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clock);
      chk("t4_valid", 32'(bus.out_valid), 32'd1);
      chk("t4_code", 32'(bus.out_code), 32'(code_of(4'h5)));
      chk("t4_last", 32'(bus.out_last), 32'd0);
      chk("t4_enc", 32'(bus.enc_data), 32'h5);
      step();
    end
    bus.out_ready = 1'b1;
    @(negedge clock);
    chk("t4_enc_after", 32'(bus.enc_data), 32'h5);
    step();
    @(negedge clock);
    chk("t4_last_beat", 32'(bus.out_last), 32'd1);
    drain();

    // Reset in the middle of a word
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h9876;
    step();
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_clear", 32'(bus.out_valid), 32'd0);
    chk("t5_busy", 32'(bus.busy), 32'd1);
    step();
    rst_n = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clock);
      chk("t5_init_ready", 32'(bus.in_ready), 32'd0);
      chk("t5_init_enc", 32'(bus.enc_data), 32'd0);
      chk("t5_init_valid", 32'(bus.out_valid), 32'd0);
      step();
    end
    run_vec(vecs[5]);
    drain();

    // Long idle after a word
    run_vec(vecs[0]);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      chk("t6_enc_hold", 32'(bus.enc_data), 32'hB);
      chk("t6_code_hold", 32'(bus.enc_code), 32'(code_of(4'hB)));
      chk("t6_valid", 32'(bus.out_valid), 32'd0);
      chk("t6_busy", 32'(bus.busy), 32'd0);
      step();
    end

    // Random traffic against the scoreboard
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.in_data   = DW'($urandom);
      step();
    end
    drain();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
